// File: rtl/bg_pkg.sv
// Shared constants and types for the background index generator.
// Holds the pipeline latency, default image geometry, the per-pixel flag
// bundle carried alongside the ROM address, and the frame-base FSM states.
package bg_pkg;

   // Clocks from a pixel entering the block to its palette index leaving it.
   localparam int BG_LATENCY    = 3;

   localparam int BG_IMG_W_DEF  = 320;
   localparam int BG_IMG_H_DEF  = 240;
   localparam int BG_ADDR_W_DEF = 17;

   // Everything that decides whether a pixel shows bitmap data or blanks to 0.
   typedef struct packed {
      logic in_img;   // x < IMG_W and y < IMG_H
      logic de;       // pixel was in active video
      logic en;       // background enabled for this pixel
      logic synced;   // a frame start has been seen since reset
   } bg_flags_t;

   localparam int BG_FLAGS_W = $bits(bg_flags_t);

   // Frame-base computation state (scroll build only).
   typedef enum logic {
      FB_IDLE,
      FB_CALC
   } fb_state_e;

   function automatic logic bg_flags_show(input bg_flags_t f);
      return f.in_img & f.de & f.en & f.synced;
   endfunction

endpackage

// File: rtl/bg_delay_line.sv
// Purpose : fixed-depth register pipeline, WIDTH bits wide, DEPTH stages deep.
// Latency : DEPTH clocks from d to q.
// Backpressure: none; shifts every clock.
// Ports   : clk, reset (async active-high, clears every stage), d in, q out.
module bg_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/bg_index_gen.sv
// Purpose : raster-tracking background bitmap addresser; emits an 8-bit palette
//           index per pixel plus matching video timing.
// Latency : 3 clocks input to bg_index/out_*; no backpressure, one pixel per clock.
// Ports   : clk, reset (async active-high); enable, vid_de/hs/vs in;
//           rom_addr out / rom_data in (ROM has 1 clock read latency);
//           scroll_step in; bg_index, out_de/hs/vs out.
// Option  : define BG_SCROLL_EN for per-frame vertical scrolling by scroll_step
//           lines; without it scroll_step is ignored and every frame starts at 0.
module bg_index_gen
   import bg_pkg::*;
#(
   parameter int IMG_W  = BG_IMG_W_DEF,
   parameter int IMG_H  = BG_IMG_H_DEF,
   parameter int ADDR_W = BG_ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              vid_de,
   input  logic              vid_hs,
   input  logic              vid_vs,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic [3:0]        scroll_step,
   output logic [7:0]        bg_index,
   output logic              out_de,
   output logic              out_hs,
   output logic              out_vs
);

   localparam int XW = $clog2(IMG_W + 1);
   localparam int YW = $clog2(IMG_H + 1);

   localparam logic [XW-1:0]   X_END     = XW'(IMG_W);
   localparam logic [YW-1:0]   Y_END     = YW'(IMG_H);
   // One extra bit so line_base + IMG_W cannot overflow before the wrap test.
   localparam logic [ADDR_W:0] LINE_STEP = (ADDR_W+1)'(IMG_W);
   localparam logic [ADDR_W:0] IMG_SIZE  = (ADDR_W+1)'(IMG_W * IMG_H);

   logic              vs_prev;
   logic              de_prev;
   logic              synced;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] line_base;

   logic              vs_rise;
   logic              de_fall;
   logic              x_in;
   logic              y_in;
   logic [ADDR_W:0]   line_sum;
   logic [ADDR_W-1:0] line_next;
   logic [ADDR_W-1:0] pix_addr;

   // Frame base hand-off from the scroll logic.
   logic              fb_load;
   logic [ADDR_W-1:0] fb_value;

   assign vs_rise   = vid_vs & ~vs_prev;
   assign de_fall   = de_prev & ~vid_de;
   assign x_in      = (x < X_END);
   assign y_in      = (y < Y_END);
   assign line_sum  = {1'b0, line_base} + LINE_STEP;
   // Wrap to the top of the bitmap; only reachable when scrolling or past the last line.
   assign line_next = (line_sum >= IMG_SIZE) ? '0 : line_sum[ADDR_W-1:0];
   assign pix_addr  = line_base + ADDR_W'(x);

   // ------------------------------------------------------------------
   // Raster counters and ROM address
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_prev   <= 1'b0;
         de_prev   <= 1'b0;
         synced    <= 1'b0;
         x         <= '0;
         y         <= '0;
         line_base <= '0;
         rom_addr  <= '0;
      end else begin
         vs_prev <= vid_vs;
         de_prev <= vid_de;

         if (vs_rise) begin
            synced <= 1'b1;
         end

         // Past the right edge the address holds on the last in-image pixel.
         if (vid_de && x_in) begin
            rom_addr <= pix_addr;
         end

         // Frame start wins over everything; the scrolled base (if any)
         // lands later in vertical blank through fb_load.
         if (vs_rise) begin
            line_base <= '0;
         end else if (fb_load) begin
            line_base <= fb_value;
         end else if (de_fall) begin
            line_base <= line_next;
         end

         if (vs_rise) begin
            x <= '0;
            y <= '0;
         end else if (de_fall) begin
            x <= '0;
            if (y_in) begin
               y <= y + YW'(1);
            end
         end else if (vid_de && x_in) begin
            x <= x + XW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame base: scroll * IMG_W by repeated addition during vertical blank
   // ------------------------------------------------------------------
`ifdef BG_SCROLL_EN
   localparam int SW = $clog2(IMG_H + 16);

   fb_state_e         fb_state;
   fb_state_e         fb_state_nxt;
   logic [SW-1:0]     scroll;
   logic [SW-1:0]     scroll_nxt;
   logic [SW-1:0]     fb_cnt;
   logic [SW-1:0]     fb_cnt_nxt;
   logic [ADDR_W-1:0] fb_acc;
   logic [ADDR_W-1:0] fb_acc_nxt;
   logic [SW-1:0]     scroll_sum;
   logic [SW-1:0]     scroll_new;

   // scroll < IMG_H and step <= 15, so one conditional subtract is a full modulo.
   assign scroll_sum = scroll + SW'(scroll_step);
   assign scroll_new = (scroll_sum >= SW'(IMG_H)) ? (scroll_sum - SW'(IMG_H)) : scroll_sum;
   assign fb_value   = fb_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_state <= FB_IDLE;
         scroll   <= '0;
         fb_cnt   <= '0;
         fb_acc   <= '0;
      end else begin
         fb_state <= fb_state_nxt;
         scroll   <= scroll_nxt;
         fb_cnt   <= fb_cnt_nxt;
         fb_acc   <= fb_acc_nxt;
      end
   end

   // The count takes up to IMG_H clocks; vertical blank is always far longer,
   // so the base is loaded before the first active line of the frame.
   always_comb begin
      fb_state_nxt = fb_state;
      scroll_nxt   = scroll;
      fb_cnt_nxt   = fb_cnt;
      fb_acc_nxt   = fb_acc;
      fb_load      = 1'b0;
      if (vs_rise) begin
         scroll_nxt   = scroll_new;
         fb_cnt_nxt   = scroll_new;
         fb_acc_nxt   = '0;
         fb_state_nxt = FB_CALC;
      end else begin
         case (fb_state)
            FB_CALC: begin
               if (fb_cnt == '0) begin
                  fb_load      = 1'b1;
                  fb_state_nxt = FB_IDLE;
               end else begin
                  fb_acc_nxt = fb_acc + ADDR_W'(IMG_W);
                  fb_cnt_nxt = fb_cnt - SW'(1);
               end
            end
            default: begin
               fb_state_nxt = FB_IDLE;
            end
         endcase
      end
   end
`else
   logic unused_scroll_step;

   assign fb_load            = 1'b0;
   assign fb_value           = '0;
   assign unused_scroll_step = ^scroll_step;
`endif

   // ------------------------------------------------------------------
   // Per-pixel flags and timing, delayed to meet rom_data
   // ------------------------------------------------------------------
   bg_flags_t               pix_flags;
   logic [BG_FLAGS_W-1:0]   flags_raw;
   bg_flags_t               flags_q;
   logic [2:0]              sync_q;

   always_comb begin
      pix_flags        = '0;
      pix_flags.in_img = x_in & y_in;
      pix_flags.de     = vid_de;
      pix_flags.en     = enable;
      pix_flags.synced = synced;
   end

   // Flags need one stage less than the timing: the final stage is bg_index itself.
   bg_delay_line #(
      .WIDTH (BG_FLAGS_W),
      .DEPTH (BG_LATENCY - 1)
   ) u_flag_dly (
      .clk   (clk),
      .reset (reset),
      .d     (pix_flags),
      .q     (flags_raw)
   );

   assign flags_q = bg_flags_t'(flags_raw);

   bg_delay_line #(
      .WIDTH (3),
      .DEPTH (BG_LATENCY)
   ) u_sync_dly (
      .clk   (clk),
      .reset (reset),
      .d     ({vid_de, vid_hs, vid_vs}),
      .q     (sync_q)
   );

   assign {out_de, out_hs, out_vs} = sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bg_index <= '0;
      end else begin
         bg_index <= bg_flags_show(flags_q) ? rom_data : 8'h00;
      end
   end

endmodule

// File: doc/bg_index_gen.md
# bg_index_gen

Background index generator for the video output path. Tracks raster position from the incoming video timing and addresses the background bitmap ROM, which holds one 8-bit palette index per pixel. It emits `bg_index` plus video timing delayed to match, ready to drive the 256-entry background palette LUT downstream. It also handles out-of-image blanking, frame synchronisation and optional vertical scrolling.

## Interface
Parameters:
- `IMG_W`, 320, bitmap width in pixels.
- `IMG_H`, 240, bitmap height in lines.
- `ADDR_W`, 17, ROM address width; must satisfy IMG_W*IMG_H ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  pixel clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  background on; when 0, `bg_index` is forced to 0 and timing still passes through.
- `vid_de`  in  1  active-video enable.
- `vid_hs`  in  1  horizontal sync.
- `vid_vs`  in  1  vertical sync; the rising edge marks frame start.
- `rom_addr`  out  ADDR_W  bitmap ROM address (registered).
- `rom_data`  in  8  ROM read data, valid one clock after `rom_addr`.
- `scroll_step`  in  4  lines advanced per frame (only with BG_SCROLL_EN).
- `bg_index`  out  8  palette index for the LUT.
- `out_de`, `out_hs`, `out_vs`  out  1 each  timing aligned to `bg_index`.

## Operation
- Reset sets `x`, `y`, `line_base`, `scroll`, `synced` and all delay stages to 0, and sets `rom_addr` to 0. All outputs reset to 0.
- `synced` is set on the first `vid_vs` rising edge after reset. While `synced` is 0, `bg_index` is 0 and the timing outputs still follow the inputs with normal latency.
- On a `vid_vs` rising edge: `x`←0, `y`←0, `line_base`←frame base. The frame base is 0, or scroll*IMG_W with scrolling enabled. A sync edge in mid-line takes priority over every other counter update.
- Each cycle with `vid_de`=1: `rom_addr`←`line_base`+`x`, then `x`←`x`+1. `x` saturates at IMG_W.
- On a `vid_de` falling edge (end of an active line): `x`←0 and `y`←`y`+1, saturating at IMG_H.
  - `line_base`←`line_base`+IMG_W.
  - If the result reaches IMG_W*IMG_H, it wraps to 0. This wrap only matters when scrolling.
- A pixel is in-image when `x`<IMG_W and `y`<IMG_H. This flag is carried alongside the address.
- Output index: `bg_index`←`rom_data` only if the pixel is in-image, `vid_de` was 1, `enable`=1 and `synced`=1; otherwise 0.
- Address arithmetic is unsigned ADDR_W-bit. No multiplier is used; the address is built incrementally from `line_base`.

## Timing
- Fixed latency of 3 clocks from input to output:
  - Cycle 0: `vid_de` sampled.
  - Cycle 1: `rom_addr` valid.
  - Cycle 2: `rom_data` valid.
  - Cycle 3: `bg_index` valid.
- `out_de`/`out_hs`/`out_vs` are the inputs delayed exactly 3 clocks. The LUT stage downstream adds its own 1 clock; delaying timing for that is its consumer's job.
- There is no backpressure; the block runs continuously at one pixel per clock.
- Asserting `reset` mid-frame zeroes all outputs immediately. Output stays blank until the next `vid_vs` rising edge.
- `enable` is sampled together with the pixel in cycle 0 and takes effect 3 clocks later.

## Configuration
- `BG_SCROLL_EN` defined:
  - On each `vid_vs` rising edge, `scroll`←(`scroll`+`scroll_step`) mod IMG_H.
  - The new frame base is the updated `scroll`*IMG_W, computed by repeated addition during vertical blank and registered before the first active line.
  - Lines wrap through `line_base` wrap-around.
- `BG_SCROLL_EN` undefined: `scroll` is constant 0, frame base is 0, and the `scroll_step` port is present but ignored.

## Structure
- Package `bg_pkg`:
  - `BG_LATENCY`=3.
  - Default `IMG_W`/`IMG_H`/`ADDR_W` constants.
  - The in-image/valid flag bundle typedef.
- Sub-module `bg_delay_line`: parameterised width/depth register pipeline, used for the sync signals and the per-pixel valid flags.

## Test plan
- Reset, then a `vid_vs` edge, then a 320-pixel line on `vid_de` → `rom_addr` counts 0..319 starting 1 clock after `de`; `bg_index` equals ROM content with 3-clock latency.
- Second line → `rom_addr` starts at 320. Line 240 with `de` active → `bg_index`=0 throughout.
- `vid_de` held high for 330 pixels → pixels 320..329 produce `bg_index`=0, and `rom_addr` holds at `line_base`+319 or less.
- `enable`=0 during pixels 100..109 → exactly those 10 outputs are 0, 3 clocks later; `out_de` is unaffected.
- Reset asserted mid-line 50 → outputs 0 immediately and stay 0 until the next `vid_vs` edge; the next frame starts at address 0.
- With BG_SCROLL_EN and `scroll_step`=5, after 48 frames `scroll` wraps to 0.
  - In frame 1, line 0 reads address 1600.
  - When `scroll`=235, line 5 reads address 0.
